bb_scheduler: RTL and testbench

Round-robin scheduler that shares the single black_box datapath between NUM_REQ byte producers. It accepts one byte per grant over a valid/ready handshake and presents it to the black_box for exactly one cycle with BB_READY asserted. It then enforces a programmable idle gap before the next grant, which paces writes toward the LCD side. The block sits directly upstream of black_box; its BB_DATA_O/BB_READY_O drive the black_box DATA_I/BB_READY_I.

---
 rtl/bb_scheduler.sv | 121 ++++++++++++
 tb/tb_bb_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bb_scheduler.sv
// Round-robin scheduler feeding the shared black_box datapath: one byte per grant,
// strobed for a single cycle, followed by a programmable idle gap.
module bb_scheduler #(
    parameter int PAYLOAD_BITS = 8,
    parameter int NUM_REQ      = 4,
    parameter int GAP_W        = 8,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                            CLK_I,
    input  logic                            RST_N_I,
    input  logic [NUM_REQ-1:0]              REQ_VALID_I,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] REQ_DATA_I,
    output logic [NUM_REQ-1:0]              REQ_READY_O,
    input  logic [GAP_W-1:0]                GAP_CYCLES_I,
    output logic [PAYLOAD_BITS-1:0]         BB_DATA_O,
    output logic                            BB_READY_O,
    output logic [ID_W-1:0]                 GRANT_ID_O,
    output logic                            BUSY_O
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    state_t                  state_q;
    logic [ID_W-1:0]         ptr_q;
    logic [PAYLOAD_BITS-1:0] data_q;
    logic [GAP_W-1:0]        gap_q;

    logic [PAYLOAD_BITS-1:0] req_bytes [NUM_REQ];
    logic                    hit;
    logic [ID_W-1:0]         hit_idx;
    logic [ID_W:0]           cand_w;
    logic [ID_W-1:0]         cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = REQ_DATA_I[g*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    // Walk from the farthest candidate back to ptr so the nearest valid index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        cand_w  = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_w = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (cand_w >= (ID_W+1)'(NUM_REQ)) begin
                cand_w = cand_w - (ID_W+1)'(NUM_REQ);
            end
            cand = cand_w[ID_W-1:0];
            if (REQ_VALID_I[cand]) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end
    end

    // Ready is held low while reset is asserted so every output shows its reset value.
    always_comb begin
        REQ_READY_O = '0;
        if (RST_N_I && (state_q == IDLE) && hit) begin
            REQ_READY_O[hit_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            data_q     <= '0;
            gap_q      <= '0;
            BB_DATA_O  <= '0;
            BB_READY_O <= 1'b0;
            GRANT_ID_O <= '0;
            BUSY_O     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        data_q     <= req_bytes[hit_idx];
                        GRANT_ID_O <= hit_idx;
                        ptr_q      <= (hit_idx == ID_W'(NUM_REQ - 1)) ? '0 : hit_idx + ID_W'(1);
                        gap_q      <= GAP_CYCLES_I;
                        BB_DATA_O  <= req_bytes[hit_idx];
                        BB_READY_O <= 1'b1;
                        BUSY_O     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    BB_DATA_O  <= '0;
                    BB_READY_O <= 1'b0;
                    if (gap_q != '0) begin
                        state_q <= GAP;
                    end else begin
                        BUSY_O  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                GAP: begin
                    // gap_q is the down-counter; the last gap cycle is the one where it reads 1.
                    gap_q <= gap_q - GAP_W'(1);
                    if (gap_q <= GAP_W'(1)) begin
                        BUSY_O  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    BB_DATA_O  <= '0;
                    BB_READY_O <= 1'b0;
                    BUSY_O     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bb_scheduler.sv
// Directed bench for bb_scheduler: grant order, strobe timing, gap pacing, reset and skip.
module tb_bb_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  gap_cycles;
    logic [7:0]  bb_data;
    logic        bb_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  bb_out;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_ids   [5] = '{0, 1, 2, 3, 0};
    int exp_bytes [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

    bb_scheduler #(
        .PAYLOAD_BITS(8),
        .NUM_REQ     (4),
        .GAP_W       (8)
    ) dut (
        .CLK_I       (clk),
        .RST_N_I     (rst_n),
        .REQ_VALID_I (req_valid),
        .REQ_DATA_I  (req_data),
        .REQ_READY_O (req_ready),
        .GAP_CYCLES_I(gap_cycles),
        .BB_DATA_O   (bb_data),
        .BB_READY_O  (bb_ready),
        .GRANT_ID_O  (grant_id),
        .BUSY_O      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for black_box: registers the byte on a strobe, shows 0 otherwise.
    always @(posedge clk) bb_out <= bb_ready ? bb_data : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        req_data   = 32'h0;
        gap_cycles = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_strobe", 32'(bb_ready), 32'h0);
        chk("rst_data", 32'(bb_data), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Single requester, G=0
        req_valid      = 4'b0010;
        req_data[15:8] = 8'hA5;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h2);
        tick();
        chk("t1_strobe", 32'(bb_ready), 32'h1);
        chk("t1_data", 32'(bb_data), 32'hA5);
        chk("t1_grant", 32'(grant_id), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_ready_issue", 32'(req_ready), 32'h0);
        req_valid = 4'b0000;
        tick();
        chk("t1_bb_out", 32'(bb_out), 32'hA5);
        chk("t1_strobe_off", 32'(bb_ready), 32'h0);
        chk("t1_data_off", 32'(bb_data), 32'h0);
        chk("t1_busy_off", 32'(busy), 32'h0);
        tick();
        chk("t1_bb_out_clr", 32'(bb_out), 32'h0);

        // All four held valid from ptr=0, G=0
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_data  = 32'h43322110;
        req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            chk("t2_ready", 32'(req_ready), 32'(1) << exp_ids[n]);
            chk("t2_no_strobe", 32'(bb_ready), 32'h0);
            tick();
            chk("t2_strobe", 32'(bb_ready), 32'h1);
            chk("t2_grant", 32'(grant_id), 32'(exp_ids[n]));
            chk("t2_data", 32'(bb_data), 32'(exp_bytes[exp_ids[n]]));
            tick();
        end

        // Gap enforcement, G=3, ptr=1
        req_valid     = 4'b0011;
        gap_cycles    = 8'd3;
        req_data[7:0] = 8'h5A;
        req_data[15:8] = 8'hB4;
        #1;
        chk("t3_ready1", 32'(req_ready), 32'h2);
        tick();
        chk("t3_strobe1", 32'(bb_ready), 32'h1);
        chk("t3_data1", 32'(bb_data), 32'hB4);
        chk("t3_busy_a", 32'(busy), 32'h1);
        tick();
        gap_cycles = 8'd0;
        chk("t3_busy_b", 32'(busy), 32'h1);
        chk("t3_gap_strobe", 32'(bb_ready), 32'h0);
        chk("t3_gap_ready", 32'(req_ready), 32'h0);
        tick();
        chk("t3_busy_c", 32'(busy), 32'h1);
        tick();
        chk("t3_busy_d", 32'(busy), 32'h1);
        chk("t3_gap_ready2", 32'(req_ready), 32'h0);
        tick();
        chk("t3_busy_end", 32'(busy), 32'h0);
        chk("t3_ready0", 32'(req_ready), 32'h1);
        tick();
        chk("t3_strobe2", 32'(bb_ready), 32'h1);
        chk("t3_data2", 32'(bb_data), 32'h5A);
        chk("t3_grant2", 32'(grant_id), 32'h0);
        req_valid = 4'b0000;
        tick();

        // Wrap and skip: grant 2 leaves ptr=3, then only 0 and 2 valid
        req_valid       = 4'b0100;
        req_data[23:16] = 8'h77;
        #1;
        chk("t4_ready2", 32'(req_ready), 32'h4);
        tick();
        chk("t4_grant2", 32'(grant_id), 32'h2);
        req_valid     = 4'b0101;
        req_data[7:0] = 8'h55;
        tick();
        chk("t4_ready_wrap", 32'(req_ready), 32'h1);
        tick();
        chk("t4_grant_wrap", 32'(grant_id), 32'h0);
        chk("t4_data_wrap", 32'(bb_data), 32'h55);
        tick();
        chk("t4_ready_next", 32'(req_ready), 32'h4);
        tick();
        chk("t4_grant_next", 32'(grant_id), 32'h2);
        chk("t4_data_next", 32'(bb_data), 32'h77);
        req_valid = 4'b0000;
        tick();

        // Reset asserted in the second gap cycle
        gap_cycles      = 8'd5;
        req_valid       = 4'b0010;
        req_data[15:8]  = 8'h99;
        #1;
        chk("t5_ready1", 32'(req_ready), 32'h2);
        tick();
        chk("t5_strobe", 32'(bb_ready), 32'h1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_grant", 32'(grant_id), 32'h0);
        chk("t5_rst_strobe", 32'(bb_ready), 32'h0);
        chk("t5_rst_data", 32'(bb_data), 32'h0);
        chk("t5_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst_n      = 1'b1;
        req_data   = 32'h3CEEC1C0;
        req_valid  = 4'b1111;
        gap_cycles = 8'd2;
        #1;
        chk("t5_ready_after", 32'(req_ready), 32'h1);
        tick();
        chk("t5_grant_after", 32'(grant_id), 32'h0);
        chk("t5_data_after", 32'(bb_data), 32'hC0);

        // req2 withdraws valid during the gap and must be skipped
        req_valid = 4'b1100;
        tick();
        chk("t6_busy_g1", 32'(busy), 32'h1);
        req_valid = 4'b1000;
        tick();
        chk("t6_busy_g2", 32'(busy), 32'h1);
        chk("t6_gap_strobe", 32'(bb_ready), 32'h0);
        tick();
        chk("t6_busy_idle", 32'(busy), 32'h0);
        chk("t6_ready3", 32'(req_ready), 32'h8);
        tick();
        chk("t6_grant3", 32'(grant_id), 32'h3);
        chk("t6_data3", 32'(bb_data), 32'h3C);
        req_valid = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
